// File: rtl/multibyte_add_sequencer_if.sv
// Operand/result handshake and external 8-bit adder hookup for multibyte_add_sequencer.
// The sequencer takes the slave modport; the environment and the adder side take the master modport.
interface multibyte_add_sequencer_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [7:0]   add_a;
  logic [7:0]   add_b;
  logic         add_cin;
  logic [7:0]   add_y;
  logic         add_cout;

  modport master (
    output start, a_in, b_in, cin, add_y, add_cout,
    input  busy, done, sum, cout, ovf, add_a, add_b, add_cin
  );

  modport slave (
    input  start, a_in, b_in, cin, add_y, add_cout,
    output busy, done, sum, cout, ovf, add_a, add_b, add_cin
  );
endinterface

// File: rtl/multibyte_add_sequencer.sv
// Feeds an external 8-bit ripple adder one byte per cycle (LSB first).
// Byte carries are chained, and the wide sum, carry and signed overflow are published on completion.
module multibyte_add_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  multibyte_add_sequencer_if.slave       bus
);
  localparam int W    = 8 * NBYTES;
  localparam int IDXW = $clog2(NBYTES);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;
  logic            last_s;

  assign last_s = (idx_q == IDXW'(NBYTES - 1));

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Adder drive and busy flag; the adder sees zeros whenever no run is in flight
  always_comb begin
    bus.busy    = 1'b0;
    bus.add_a   = 8'h00;
    bus.add_b   = 8'h00;
    bus.add_cin = 1'b0;
    case (state_q)
      ST_RUN: begin
        bus.busy    = 1'b1;
        bus.add_a   = a_q[{idx_q, 3'b000} +: 8];
        bus.add_b   = b_q[{idx_q, 3'b000} +: 8];
        bus.add_cin = carry_q;
      end
      ST_IDLE: begin
        bus.busy    = 1'b0;
      end
      default: begin
        bus.busy    = 1'b0;
      end
    endcase
  end

  // Datapath next-state: operand capture, byte accumulation and completion
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          carry_d = bus.cin;
          idx_d   = {IDXW{1'b0}};
        end else begin
          idx_d   = idx_q;
        end
      end
      ST_RUN: begin
        acc_d[{idx_q, 3'b000} +: 8] = bus.add_y;
        carry_d = bus.add_cout;
        idx_d   = idx_q + IDXW'(1);
        // The top byte goes straight from the adder into sum, so acc never has to hold it first
        if (last_s) begin
          sum_d  = {bus.add_y, acc_q[W-9:0]};
          cout_d = bus.add_cout;
          ovf_d  = (a_q[W-1] == b_q[W-1]) && (bus.add_y[7] != a_q[W-1]);
          done_d = 1'b1;
        end else begin
          done_d = 1'b0;
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      acc_q   <= {W{1'b0}};
      sum_q   <= {W{1'b0}};
      idx_q   <= {IDXW{1'b0}};
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Scoreboard bench for multibyte_add_sequencer with a behavioural 8-bit adder closing the loop.
// Directed vectors carry hand-computed results; a monitor checks every done pulse against the queue.
module tb_multibyte_add_sequencer;
  logic clk;
  logic reset;

  multibyte_add_sequencer_if #(.NBYTES(4)) bus ();

  multibyte_add_sequencer #(.NBYTES(4)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  // The external combinational ripple adder
  assign {bus.add_cout, bus.add_y} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {8'h00, bus.add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && bus.done === 1'b1) begin
      exp_t e;
      chk("done_has_expectation", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sum",  64'(bus.sum),  64'(e.s));
        chk("cout", 64'(bus.cout), 64'(e.c));
        chk("ovf",  64'(bus.ovf),  64'(e.o));
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic c,
                       input logic push, input logic [31:0] es, input logic ec, input logic eo);
    int g;
    exp_t e;
    g = 0;
    while (bus.busy !== 1'b0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("idle_before_start", 64'(bus.busy), 64'd0);
    bus.a_in  = a;
    bus.b_in  = b;
    bus.cin   = c;
    bus.start = 1'b1;
    if (push) begin
      e.s = es;
      e.c = ec;
      e.o = eo;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.done !== 1'b1 && cyc < 50);
    chk("done_within_budget", 64'(bus.done), 64'd1);
  endtask

  initial begin
    int          cyc;
    int          busy_cnt;
    logic [3:0]  cin_seq;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a_in  = 32'h0;
    bus.b_in  = 32'h0;
    bus.cin   = 1'b0;
    #12;
    chk("rst_busy",  64'(bus.busy),  64'd0);
    chk("rst_done",  64'(bus.done),  64'd0);
    chk("rst_sum",   64'(bus.sum),   64'd0);
    chk("rst_cout",  64'(bus.cout),  64'd0);
    chk("rst_ovf",   64'(bus.ovf),   64'd0);
    chk("rst_add_a", 64'(bus.add_a), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: latency and busy length
    issue(32'h0000005E, 32'h0000002C, 1'b0, 1'b1, 32'h0000008A, 1'b0, 1'b0);
    cyc = 0;
    busy_cnt = 0;
    while (cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (bus.done === 1'b1) break;
      if (bus.busy === 1'b1) busy_cnt++;
    end
    chk("t1_done_latency", 64'(cyc), 64'd5);
    chk("t1_busy_cycles", 64'(busy_cnt), 64'd4);

    // 2: carry ripple through every byte
    issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0);
    cin_seq = 4'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cin_seq = {cin_seq[2:0], bus.add_cin};
    end
    chk("t2_add_cin_seq", 64'(cin_seq), 64'h7);
    wait_done(cyc);

    // 3: signed overflow both directions
    issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1);
    wait_done(cyc);
    issue(32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b1);
    wait_done(cyc);

    // 4: initial carry-in participates in byte 0
    issue(32'h000000EA, 32'h000000D4, 1'b1, 1'b1, 32'h000001BF, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_byte0_y", 64'(bus.add_y), 64'hBF);
    chk("t4_byte0_cout", 64'(bus.add_cout), 64'd1);
    @(negedge clk);
    chk("t4_byte1_cin", 64'(bus.add_cin), 64'd1);
    wait_done(cyc);

    // 5: start while busy is ignored; start held into the done cycle is accepted
    issue(32'h01020304, 32'h10203040, 1'b0, 1'b1, 32'h11223344, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.a_in  = 32'hFFFFFFFF;
    bus.b_in  = 32'hFFFFFFFF;
    bus.cin   = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("t5_still_busy", 64'(bus.busy), 64'd1);
    bus.a_in  = 32'h00000100;
    bus.b_in  = 32'h000000FF;
    bus.cin   = 1'b1;
    bus.start = 1'b1;
    wait_done(cyc);
    begin
      exp_t e;
      e.s = 32'h00000200;
      e.c = 1'b0;
      e.o = 1'b0;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.done !== 1'b1 && cyc < 50);
    chk("t5_done_spacing", 64'(cyc), 64'd5);

    // 6: reset mid-run aborts without a done pulse
    issue(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("t6_byte2_a", 64'(bus.add_a), 64'h34);
    chk("t6_byte2_b", 64'(bus.add_b), 64'h11);
    chk("t6_sum_held", 64'(bus.sum), 64'h200);
    reset = 1'b1;
    #1;
    chk("t6_rst_busy",  64'(bus.busy),  64'd0);
    chk("t6_rst_add_a", 64'(bus.add_a), 64'd0);
    chk("t6_rst_add_b", 64'(bus.add_b), 64'd0);
    chk("t6_rst_sum",   64'(bus.sum),   64'd0);
    chk("t6_rst_done",  64'(bus.done),  64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("t6_sum_after_abort", 64'(bus.sum), 64'd0);
    issue(32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h23456789, 1'b0, 1'b0);
    wait_done(cyc);

    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/multibyte_add_sequencer.md
Name: multibyte_add_sequencer

Overview:
- Sequential front-end for the team's combinational 8-bit ripple adder, which has ports A, B, carry_in, Y and carry_out.
- Accepts two NBYTES-wide operands, feeds the adder one byte per cycle (LSB byte first), and chains each byte's carry-out into the next byte's carry-in.
- Collects the adder's 8-bit results into a wide sum.
- The adder sits outside this block. This block drives the adder's inputs and consumes its outputs in the same cycle.

Parameters:
NBYTES, 4, number of 8-bit bytes per operand (>=2); operand width W = 8*NBYTES

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous active-high reset
start  input  1  request; accepted only when busy=0
a_in  input  W  operand A, sampled on the accepting edge
b_in  input  W  operand B, sampled on the accepting edge
cin  input  1  initial carry-in, sampled on the accepting edge
busy  output  1  high while bytes are being processed
done  output  1  one-cycle pulse when sum/cout/ovf are updated
sum  output  W  registered result, held until the next completion
cout  output  1  carry out of the MSB byte
ovf  output  1  signed two's-complement overflow
add_a  output  8  to adder A
add_b  output  8  to adder B
add_cin  output  1  to adder carry_in
add_y  input  8  from adder Y
add_cout  input  1  from adder carry_out

Behaviour:
- Reset (async, immediate): state=IDLE; busy=0; done=0; sum=0; cout=0; ovf=0; idx=0; internal registers cleared.
- States: IDLE, RUN.
- IDLE:
  - add_a=0, add_b=0, add_cin=0.
  - start=1 at a rising edge: latch a_in/b_in/cin into a_reg/b_reg/carry_reg; idx<=0; go to RUN.
- RUN, combinational outputs:
  - busy=1.
  - add_a = a_reg[8*idx +: 8]; add_b = b_reg[8*idx +: 8]; add_cin = carry_reg.
- RUN, each rising edge:
  - acc[8*idx +: 8] <= add_y; carry_reg <= add_cout; idx <= idx+1.
- Completion, on the edge where idx==NBYTES-1:
  - sum <= {add_y, acc[W-9:0]}; cout <= add_cout.
  - ovf <= (a_reg[W-1]==b_reg[W-1]) && (add_y[7]!=a_reg[W-1]).
  - done<=1; state<=IDLE.
- done:
  - Registered pulse, high for exactly one cycle.
  - Cleared on the next edge unless another completion occurs.
- Latency: start is sampled at edge 0. Bytes are captured at edges 1..NBYTES. done is high in the cycle after edge NBYTES.
- Throughput: start is accepted in the cycle done=1, since state is already IDLE. Back-to-back operations therefore run every NBYTES+1 edges.
- start while busy=1: ignored, with no side effects. start must be re-asserted once busy=0.
- sum/cout/ovf: change only at completion or reset. Intermediate bytes are never visible on sum.
- Arithmetic: result is modulo 2^W. cout is the unsigned carry out. ovf follows signed semantics. cin participates only in byte 0.
- Reset mid-RUN: abort. No done pulse, sum stays 0, adder-drive ports return to 0 immediately.
- a_in/b_in/cin changing during RUN: no effect.

Test Plan:
1. NBYTES=4; a=0x0000005E, b=0x0000002C, cin=0 -> done one cycle after 4th capture edge; sum=0x0000008A, cout=0, ovf=0; busy high for exactly 4 cycles.
2. a=0xFFFFFFFF, b=0x00000001, cin=0 -> add_cin observed 0,1,1,1 across bytes; sum=0x00000000, cout=1, ovf=0.
3. a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1. Then a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1.
4. a=0x000000EA, b=0x000000D4, cin=1 -> byte0 add_y=0xBF with add_cout=1; byte1 add_cin=1; sum=0x000001BF, cout=0.
5. Pulse start with new operands mid-RUN -> ignored, first result unchanged. Hold start=1 through the done cycle -> second op accepted that cycle, second done exactly 5 edges after first done.
6. Assert reset at byte 2 of a run (a=0x12345678, b=0x11111111) -> busy=0, done never pulses, sum=0, add_a/add_b=0 immediately. After release, the same operands yield sum=0x23456789, cout=0.
